// File: rtl/gl_bram_arbiter.sv
// gl_bram_arbiter: shares the GL core BRAM read port between fetch
// (single words) and the decode/matmul data path (1-4 word bursts).
// Ports: clk, reset (sync, active low); fetch if_req/if_addr ->
// if_grant/if_valid/if_data; data dr_req/dr_addr/dr_len ->
// dr_grant/dr_done/dr_data_0..3; stall; BRAM bram_enable/bram_rst/
// bram_addr_out/bram_data_in.
// Macro GL_BRAM_ARB_FAIR_EN selects round-robin tie-break;
// undefined gives fixed priority with data winning ties.
module gl_bram_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_grant,
  output logic        if_valid,
  output logic [31:0] if_data,
  input  logic        dr_req,
  input  logic [31:0] dr_addr,
  input  logic [1:0]  dr_len,
  output logic        dr_grant,
  output logic        dr_done,
  output logic [31:0] dr_data_0,
  output logic [31:0] dr_data_1,
  output logic [31:0] dr_data_2,
  output logic [31:0] dr_data_3,
  output logic        stall,
  output logic        bram_enable,
  output logic        bram_rst,
  output logic [31:0] bram_addr_out,
  input  logic [31:0] bram_data_in
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  typedef struct packed {
    logic       v;
    logic       dat;
    logic [1:0] idx;
    logic       last;
  } tag_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] nxt_q, nxt_d;
  logic [31:0] addr_d;
  logic        gnt_if, gnt_dr;
  tag_t        iss_q, iss_d;
  tag_t        pipe_q [RD_LAT];
  tag_t        tail;
  logic [31:0] if_data_q;
  logic [31:0] dr_q [4];
  logic [31:0] dr_out [4];
  logic        if_pend, dr_pend;
  logic        pick_dr;
  logic        ret_if, ret_dr;

`ifdef GL_BRAM_ARB_FAIR_EN
  logic        last_dr_q;
`endif

  // A request whose grant pulses this cycle is already consumed,
  // even though the requester still holds it until the next edge.
  assign if_pend = if_req & ~if_grant;
  assign dr_pend = dr_req & ~dr_grant;
  assign stall   = if_pend;

`ifdef GL_BRAM_ARB_FAIR_EN
  // On a tie, the side not granted last wins.
  assign pick_dr = dr_pend & (~if_pend | ~last_dr_q);
`else
  assign pick_dr = dr_pend;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nxt_d   = nxt_q;
    addr_d  = bram_addr_out;
    gnt_if  = 1'b0;
    gnt_dr  = 1'b0;
    iss_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_dr) begin
          gnt_dr = 1'b1;
          addr_d = dr_addr;
          nxt_d  = dr_addr + 32'd4;
          cnt_d  = dr_len;
          idx_d  = 2'd1;
          iss_d  = '{v: 1'b1, dat: 1'b1, idx: 2'd0,
                     last: (dr_len == 2'd0)};
          if (dr_len != 2'd0) state_d = BURST;
        end else if (if_pend) begin
          gnt_if = 1'b1;
          addr_d = if_addr;
          iss_d  = '{v: 1'b1, dat: 1'b0, idx: 2'd0,
                     last: 1'b1};
        end
      end
      BURST: begin
        addr_d = nxt_q;
        nxt_d  = nxt_q + 32'd4;
        idx_d  = idx_q + 2'd1;
        cnt_d  = cnt_q - 2'd1;
        iss_d  = '{v: 1'b1, dat: 1'b1, idx: idx_q,
                   last: (cnt_q == 2'd1)};
        if (cnt_q == 2'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The tail tag lines up with the BRAM word for its address;
  // returns are masked while reset is low so nothing leaks out.
  assign tail   = pipe_q[RD_LAT-1];
  assign ret_if = reset & tail.v & ~tail.dat;
  assign ret_dr = reset & tail.v & tail.dat;

  assign if_valid = ret_if;
  assign if_data  = ret_if ? bram_data_in : if_data_q;
  assign dr_done  = ret_dr & tail.last;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      dr_out[k] = dr_q[k];
      if (ret_dr && tail.idx == 2'(k))
        dr_out[k] = bram_data_in;
    end
  end

  assign dr_data_0 = dr_out[0];
  assign dr_data_1 = dr_out[1];
  assign dr_data_2 = dr_out[2];
  assign dr_data_3 = dr_out[3];
  assign bram_rst  = ~reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      nxt_q         <= '0;
      bram_addr_out <= '0;
      bram_enable   <= 1'b0;
      if_grant      <= 1'b0;
      dr_grant      <= 1'b0;
      iss_q         <= '0;
      if_data_q     <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
      for (int k = 0; k < 4; k++) dr_q[k] <= '0;
`ifdef GL_BRAM_ARB_FAIR_EN
      last_dr_q     <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      nxt_q         <= nxt_d;
      bram_addr_out <= addr_d;
      bram_enable   <= iss_d.v;
      if_grant      <= gnt_if;
      dr_grant      <= gnt_dr;
      iss_q         <= iss_d;
      pipe_q[0]     <= iss_q;
      for (int i = 1; i < RD_LAT; i++)
        pipe_q[i] <= pipe_q[i-1];
      if (ret_if) if_data_q <= bram_data_in;
      // A late word from the previous burst still lands over the clear.
      if (gnt_dr)
        for (int k = 0; k < 4; k++) dr_q[k] <= '0;
      if (ret_dr) dr_q[tail.idx] <= bram_data_in;
`ifdef GL_BRAM_ARB_FAIR_EN
      if (gnt_dr)      last_dr_q <= 1'b1;
      else if (gnt_if) last_dr_q <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_gl_bram_arbiter.sv
// tb_gl_bram_arbiter: directed bench for gl_bram_arbiter.
// Two instances share stimulus: _a with RD_LAT=1, _b with RD_LAT=2.
module tb_gl_bram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, if_req, dr_req;
  logic [31:0] if_addr, dr_addr;
  logic [1:0]  dr_len;

  logic        if_grant_a, if_valid_a, dr_grant_a, dr_done_a;
  logic        stall_a, bram_enable_a, bram_rst_a;
  logic [31:0] if_data_a, bram_addr_a, bram_din_a;
  logic [31:0] dra [4];
  logic        if_grant_b, if_valid_b, dr_grant_b, dr_done_b;
  logic        stall_b, bram_enable_b, bram_rst_b;
  logic [31:0] if_data_b, bram_addr_b, bram_din_b;
  logic [31:0] drb [4];

  int vec = 0;
  int miss = 0;

`ifdef GL_BRAM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  gl_bram_arbiter #(.RD_LAT(1)) u_a (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_grant(if_grant_a), .if_valid(if_valid_a),
    .if_data(if_data_a),
    .dr_req(dr_req), .dr_addr(dr_addr), .dr_len(dr_len),
    .dr_grant(dr_grant_a), .dr_done(dr_done_a),
    .dr_data_0(dra[0]), .dr_data_1(dra[1]),
    .dr_data_2(dra[2]), .dr_data_3(dra[3]),
    .stall(stall_a), .bram_enable(bram_enable_a),
    .bram_rst(bram_rst_a), .bram_addr_out(bram_addr_a),
    .bram_data_in(bram_din_a)
  );

  gl_bram_arbiter #(.RD_LAT(2)) u_b (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_grant(if_grant_b), .if_valid(if_valid_b),
    .if_data(if_data_b),
    .dr_req(dr_req), .dr_addr(dr_addr), .dr_len(dr_len),
    .dr_grant(dr_grant_b), .dr_done(dr_done_b),
    .dr_data_0(drb[0]), .dr_data_1(drb[1]),
    .dr_data_2(drb[2]), .dr_data_3(drb[3]),
    .stall(stall_b), .bram_enable(bram_enable_b),
    .bram_rst(bram_rst_b), .bram_addr_out(bram_addr_b),
    .bram_data_in(bram_din_b)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h100: return 32'h1;
      32'h104: return 32'h2;
      32'h108: return 32'h3;
      32'h10C: return 32'h4;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  logic [31:0] ra, rb0, rb1;
  always @(posedge clk) begin
    ra  <= mem_rd(bram_addr_a);
    rb0 <= mem_rd(bram_addr_b);
    rb1 <= rb0;
  end
  assign bram_din_a = ra;
  assign bram_din_b = rb1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; if_req = 1'b0; dr_req = 1'b0;
    if_addr = '0; dr_addr = '0; dr_len = '0;
    tick(); tick();
    vec++;
    if (bram_rst_a !== 1'b1) begin miss++;
      $display("FAIL rst_bram_rst got %b want 1", bram_rst_a); end
    vec++;
    if ({if_grant_a, dr_grant_a, if_valid_a, dr_done_a,
         bram_enable_a, stall_a} !== 6'b0) begin miss++;
      $display("FAIL rst_flags got %b want 0",
        {if_grant_a, dr_grant_a, if_valid_a, dr_done_a,
         bram_enable_a, stall_a}); end
    vec++;
    if ({bram_addr_a, if_data_a, dra[0], dra[3]} !== 128'h0)
      begin miss++;
      $display("FAIL rst_data got %h %h %h want 0",
        bram_addr_a, if_data_a, dra[0]); end
    reset = 1'b1;
    tick();
    vec++;
    if ({bram_rst_a, bram_enable_a} !== 2'b00) begin miss++;
      $display("FAIL rst_release got %b want 00",
        {bram_rst_a, bram_enable_a}); end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    vec++;
    if (stall_a !== 1'b1) begin miss++;
      $display("FAIL fetch_stall_pre got %b want 1", stall_a); end
    tick();
    vec++;
    if ({if_grant_a, bram_enable_a, stall_a} !== 3'b110)
      begin miss++;
      $display("FAIL fetch_grant got %b want 110",
        {if_grant_a, bram_enable_a, stall_a}); end
    vec++;
    if (bram_addr_a !== 32'h10) begin miss++;
      $display("FAIL fetch_addr got %h want 10", bram_addr_a); end
    if_req = 1'b0;
    tick();
    vec++;
    if ({if_valid_a, if_valid_b, if_grant_a} !== 3'b100)
      begin miss++;
      $display("FAIL fetch_valid_a got %b want 100",
        {if_valid_a, if_valid_b, if_grant_a}); end
    vec++;
    if (if_data_a !== 32'hDEADBEEF) begin miss++;
      $display("FAIL fetch_data_a got %h want deadbeef",
        if_data_a); end
    tick();
    vec++;
    if ({if_valid_a, if_valid_b} !== 2'b01) begin miss++;
      $display("FAIL fetch_valid_b got %b want 01",
        {if_valid_a, if_valid_b}); end
    vec++;
    if ({if_data_a, if_data_b} !== {2{32'hDEADBEEF}}) begin
      miss++;
      $display("FAIL fetch_data_b got %h %h want deadbeef",
        if_data_a, if_data_b); end
  endtask

  task automatic test_burst();
    dr_req = 1'b1; dr_addr = 32'h100; dr_len = 2'd3;
    tick();
    vec++;
    if ({dr_grant_a, bram_enable_a} !== 2'b11 ||
        bram_addr_a !== 32'h100) begin miss++;
      $display("FAIL burst_grant got %b %h want 11 100",
        {dr_grant_a, bram_enable_a}, bram_addr_a); end
    dr_req = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      vec++;
      if (bram_addr_a !== 32'h100 + 32'(4 * k) ||
          {bram_enable_a, dr_done_a, dr_grant_a} !== 3'b100)
        begin miss++;
        $display("FAIL burst_addr%0d got %h %b want %h 100", k,
          bram_addr_a, {bram_enable_a, dr_done_a, dr_grant_a},
          32'h100 + 32'(4 * k)); end
    end
    tick();
    vec++;
    if ({dr_done_a, dr_done_b, bram_enable_a} !== 3'b100)
      begin miss++;
      $display("FAIL burst_done_a got %b want 100",
        {dr_done_a, dr_done_b, bram_enable_a}); end
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (dra[k] !== 32'(k + 1)) begin miss++;
        $display("FAIL burst_data_a%0d got %h want %h", k,
          dra[k], 32'(k + 1)); end
    end
    tick();
    vec++;
    if ({dr_done_a, dr_done_b} !== 2'b01) begin miss++;
      $display("FAIL burst_done_b got %b want 01",
        {dr_done_a, dr_done_b}); end
    vec++;
    if ({drb[0], drb[1], drb[2], drb[3]} !==
        {32'h1, 32'h2, 32'h3, 32'h4} || dra[3] !== 32'h4)
      begin miss++;
      $display("FAIL burst_data_b got %h %h %h %h want 1 2 3 4",
        drb[0], drb[1], drb[2], drb[3]); end
  endtask

  task automatic test_single();
    dr_req = 1'b1; dr_addr = 32'h500; dr_len = 2'd0;
    tick();
    vec++;
    if (dr_grant_a !== 1'b1 || bram_addr_a !== 32'h500 ||
        dra[1] !== 32'h0) begin miss++;
      $display("FAIL single_grant got %b %h %h want 1 500 0",
        dr_grant_a, bram_addr_a, dra[1]); end
    dr_req = 1'b0;
    tick();
    vec++;
    if ({dr_done_a, dr_grant_a, bram_enable_a} !== 3'b100 ||
        dra[0] !== mem_rd(32'h500) || dra[1] !== 32'h0)
      begin miss++;
      $display("FAIL single_done got %b %h %h want 100 %h 0",
        {dr_done_a, dr_grant_a, bram_enable_a}, dra[0], dra[1],
        mem_rd(32'h500)); end
    tick();
    vec++;
    if ({dr_done_a, dr_done_b} !== 2'b01) begin miss++;
      $display("FAIL single_done_b got %b want 01",
        {dr_done_a, dr_done_b}); end
  endtask

  task automatic test_fetch_during_burst();
    dr_req = 1'b1; dr_addr = 32'h300; dr_len = 2'd3;
    tick();
    vec++;
    if (dr_grant_a !== 1'b1) begin miss++;
      $display("FAIL fdb_grant got %b want 1", dr_grant_a); end
    dr_req = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 32'h40;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      #1;
      vec++;
      if ({stall_a, if_grant_a} !== 2'b10) begin miss++;
        $display("FAIL fdb_stall%0d got %b want 10", k,
          {stall_a, if_grant_a}); end
    end
    vec++;
    if (bram_addr_a !== 32'h30C) begin miss++;
      $display("FAIL fdb_last_addr got %h want 30c",
        bram_addr_a); end
    tick();
    vec++;
    if ({if_grant_a, stall_a, dr_done_a} !== 3'b101 ||
        bram_addr_a !== 32'h40) begin miss++;
      $display("FAIL fdb_if_grant got %b %h want 101 40",
        {if_grant_a, stall_a, dr_done_a}, bram_addr_a); end
    vec++;
    if (dra[3] !== mem_rd(32'h30C)) begin miss++;
      $display("FAIL fdb_data3 got %h want %h", dra[3],
        mem_rd(32'h30C)); end
    if_req = 1'b0;
    tick();
    vec++;
    if (if_valid_a !== 1'b1 || if_data_a !== mem_rd(32'h40))
      begin miss++;
      $display("FAIL fdb_fetch got %b %h want 1 %h", if_valid_a,
        if_data_a, mem_rd(32'h40)); end
    tick(); tick();
  endtask

  task automatic test_wrap();
    dr_req = 1'b1; dr_addr = 32'hFFFF_FFFC; dr_len = 2'd1;
    tick();
    vec++;
    if (bram_addr_a !== 32'hFFFF_FFFC) begin miss++;
      $display("FAIL wrap_addr0 got %h want fffffffc",
        bram_addr_a); end
    dr_req = 1'b0;
    tick();
    vec++;
    if (bram_addr_a !== 32'h0 || bram_enable_a !== 1'b1)
      begin miss++;
      $display("FAIL wrap_addr1 got %h %b want 0 1",
        bram_addr_a, bram_enable_a); end
    tick();
    vec++;
    if ({dr_done_a, bram_enable_a} !== 2'b10 ||
        dra[0] !== mem_rd(32'hFFFF_FFFC) ||
        dra[1] !== mem_rd(32'h0)) begin miss++;
      $display("FAIL wrap_done got %b %h %h want 10 %h %h",
        {dr_done_a, bram_enable_a}, dra[0], dra[1],
        mem_rd(32'hFFFF_FFFC), mem_rd(32'h0)); end
    tick();
  endtask

  task automatic do_tie(input string nm, input bit fetch_first);
    if_req = 1'b1; dr_req = 1'b1;
    if_addr = 32'h20; dr_addr = 32'h200; dr_len = 2'd0;
    tick();
    vec++;
    if ({if_grant_a, dr_grant_a} !== {fetch_first, ~fetch_first})
      begin miss++;
      $display("FAIL %s_first got if=%b dr=%b want if=%b", nm,
        if_grant_a, dr_grant_a, fetch_first); end
    if (fetch_first) if_req = 1'b0;
    else dr_req = 1'b0;
    tick();
    vec++;
    if ({if_grant_a, dr_grant_a} !== {~fetch_first, fetch_first})
      begin miss++;
      $display("FAIL %s_second got if=%b dr=%b want if=%b", nm,
        if_grant_a, dr_grant_a, ~fetch_first); end
    if_req = 1'b0; dr_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_tie();
    reset = 1'b0;
    if_req = 1'b1; dr_req = 1'b1;
    if_addr = 32'h20; dr_addr = 32'h200; dr_len = 2'd0;
    tick();
    reset = 1'b1;
    do_tie("tie1", FAIR);
    if_req = 1'b1;
    tick();
    if_req = 1'b0;
    tick();
    do_tie("tie2", 1'b0);
    dr_req = 1'b1;
    tick();
    dr_req = 1'b0;
    tick();
    do_tie("tie3", FAIR);
  endtask

  task automatic test_reset_mid();
    int pulses;
    dr_req = 1'b1; dr_addr = 32'h400; dr_len = 2'd3;
    tick();
    vec++;
    if (dr_grant_b !== 1'b1) begin miss++;
      $display("FAIL rmid_grant got %b want 1", dr_grant_b); end
    dr_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    vec++;
    if ({bram_enable_a, bram_enable_b, dr_done_a, dr_done_b,
         if_valid_a, if_valid_b} !== 6'b0) begin miss++;
      $display("FAIL rmid_flags got %b want 0",
        {bram_enable_a, bram_enable_b, dr_done_a, dr_done_b,
         if_valid_a, if_valid_b}); end
    vec++;
    if ({bram_addr_b, if_data_a, if_data_b, drb[0], drb[1],
         dra[0], dra[1]} !== 224'h0) begin miss++;
      $display("FAIL rmid_data got %h %h %h %h want 0",
        bram_addr_b, if_data_b, drb[0], dra[0]); end
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      pulses += int'(dr_done_a) + int'(dr_done_b) +
                int'(if_valid_a) + int'(if_valid_b);
    end
    vec++;
    if (pulses !== 0) begin miss++;
      $display("FAIL rmid_no_pulse got %0d want 0", pulses); end
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    vec++;
    if (if_grant_b !== 1'b1) begin miss++;
      $display("FAIL rmid_fetch_grant got %b want 1",
        if_grant_b); end
    if_req = 1'b0;
    tick();
    vec++;
    if (if_valid_b !== 1'b0) begin miss++;
      $display("FAIL rmid_fetch_early got %b want 0",
        if_valid_b); end
    tick();
    vec++;
    if (if_valid_b !== 1'b1 || if_data_b !== 32'hDEADBEEF)
      begin miss++;
      $display("FAIL rmid_fetch got %b %h want 1 deadbeef",
        if_valid_b, if_data_b); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_burst();
    test_single();
    test_fetch_during_burst();
    test_wrap();
    test_tie();
    test_reset_mid();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
